// File: rtl/qspi_prefetch_fill_if.sv
// qspi_prefetch_fill_if
// Burst read port between the prefetch fill engine and the SDRAM controller.
//   rd_avalid  fill engine -> SDRAM : burst start address valid
//   rd_addr    fill engine -> SDRAM : 16-byte aligned burst start address
//   rd_aready  SDRAM -> fill engine : address accepted
//   rd_valid   SDRAM -> fill engine : read data beat valid (no back-pressure)
//   rd_data    SDRAM -> fill engine : read data beat
// The fill engine connects through the master modport, the SDRAM
// controller (or its model) through the slave modport.
interface qspi_prefetch_fill_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  logic              rd_avalid;
  logic              rd_aready;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output rd_avalid,
    output rd_addr,
    input  rd_aready,
    input  rd_valid,
    input  rd_data
  );

  modport slave (
    input  rd_avalid,
    input  rd_addr,
    output rd_aready,
    output rd_valid,
    output rd_data
  );
endinterface

// File: rtl/qspi_prefetch_fill.sv
// qspi_prefetch_fill
// Fill engine plus an 8 x DATA_W line buffer feeding the QSPI fast-read
// responder. A prefetch request launches one 8-beat burst read on the SDRAM
// read port; returned beats are written into the line buffer in order.
// Ports:
//   sd_clk, rst        clock, asynchronous active-high reset
//   qspi_rd_req/addr   single-cycle prefetch request and line address
//   qspi_rd_busy       high while a fill is in progress
//   sd                 SDRAM burst read port (master side)
//   ram_ren/raddr      responder buffer read strobe and word index
//   ram_rdata          buffer word, combinational read
//   fill_done          one-cycle pulse at the end of every fill
//   fill_err           sticky timeout flag, cleared by the next accepted request
//   rd_hazard          pulse one cycle after a buffer read while busy
module qspi_prefetch_fill #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                 sd_clk,
  input  logic                 rst,
  input  logic                 qspi_rd_req,
  input  logic [ADDR_W-1:0]    qspi_rd_addr,
  output logic                 qspi_rd_busy,
  qspi_prefetch_fill_if.master sd,
  input  logic                 ram_ren,
  input  logic [2:0]           ram_raddr,
  output logic [DATA_W-1:0]    ram_rdata,
  output logic                 fill_done,
  output logic                 fill_err,
  output logic                 rd_hazard
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  localparam logic [7:0]        TO_LIMIT  = 8'(TIMEOUT);
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-4){1'b1}}, 4'h0};

  state_t            state;
  state_t            state_next;

  logic [DATA_W-1:0] line_buf [8];
  logic              pending;
  logic [ADDR_W-1:0] pend_addr;
  logic [2:0]        beat_cnt;
  logic [7:0]        to_cnt;

  logic [ADDR_W-1:0] req_aligned;
  logic [ADDR_W-1:0] launch_addr;
  logic [7:0]        to_cnt_inc;
  logic              accept_new;
  logic              relaunch;
  logic              capture_pending;
  logic              addr_hs;
  logic              beat_write;
  logic              timeout_hit;

  // Masking rather than slicing keeps every request address bit in use.
  assign req_aligned = qspi_rd_addr & LINE_MASK;
  assign to_cnt_inc  = to_cnt + 8'd1;

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (qspi_rd_req) state_next = ADDR;
      ADDR: if (addr_hs) state_next = DATA;
      DATA: begin
        if (beat_write && (beat_cnt == 3'd7)) state_next = DONE;
        else if (timeout_hit)                 state_next = DONE;
      end
      DONE: state_next = relaunch ? ADDR : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A request arriving in DONE is treated like a pending one and relaunches
  // straight away; it wins over any older pending address (last wins).
  // The timeout fires on the idle cycle that brings the count to TIMEOUT, so
  // fill_done rises TIMEOUT edges after the last accepted beat.
  always_comb begin
    accept_new      = (state == IDLE) && qspi_rd_req;
    relaunch        = (state == DONE) && (pending || qspi_rd_req);
    capture_pending = (state != IDLE) && qspi_rd_req && !relaunch;
    addr_hs         = (state == ADDR) && sd.rd_aready;
    beat_write      = (state == DATA) && sd.rd_valid;
    timeout_hit     = (state == DATA) && !sd.rd_valid && (to_cnt_inc == TO_LIMIT);
    launch_addr     = (relaunch && !qspi_rd_req) ? pend_addr : req_aligned;
  end

  // Status outputs are flops driven from the next state, so each one tracks
  // the current state exactly without a combinational path to the pins.
  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      qspi_rd_busy <= 1'b0;
      sd.rd_avalid <= 1'b0;
      sd.rd_addr   <= '0;
      fill_done    <= 1'b0;
      fill_err     <= 1'b0;
      rd_hazard    <= 1'b0;
      pending      <= 1'b0;
      pend_addr    <= '0;
      beat_cnt     <= 3'd0;
      to_cnt       <= 8'd0;
    end else begin
      qspi_rd_busy <= (state_next != IDLE);
      sd.rd_avalid <= (state_next == ADDR);
      fill_done    <= (state_next == DONE);
      rd_hazard    <= ram_ren && qspi_rd_busy;

      if (accept_new || relaunch) begin
        sd.rd_addr <= launch_addr;
        fill_err   <= 1'b0;
      end else if (timeout_hit) begin
        fill_err   <= 1'b1;
      end

      if (relaunch) begin
        pending   <= 1'b0;
      end else if (capture_pending) begin
        pending   <= 1'b1;
        pend_addr <= req_aligned;
      end

      if (addr_hs) begin
        beat_cnt <= 3'd0;
        to_cnt   <= 8'd0;
      end else if (beat_write) begin
        beat_cnt <= beat_cnt + 3'd1;
        to_cnt   <= 8'd0;
      end else if (state == DATA) begin
        to_cnt   <= to_cnt_inc;
      end
    end
  end

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) line_buf[i] <= '0;
    end else if (beat_write) begin
      line_buf[beat_cnt] <= sd.rd_data;
    end
  end

  // Read-during-write of the same word returns the old value until the edge.
  assign ram_rdata = line_buf[ram_raddr];

endmodule

// File: doc/qspi_prefetch_fill.md
Name: qspi_prefetch_fill

Overview:
- Fill engine plus 8x16-bit line buffer feeding the QSPI fast-read responder.
- On a prefetch request it issues one 8-beat burst read to the SDRAM controller's read port and writes the returned words into the line buffer.
- The QSPI responder reads the buffer through an asynchronous read port (ram_ren/ram_raddr/ram_rdata).
- Single clock domain (sd_clk). Any synchronisation of qspi_rd_req from the qspi_clk domain happens outside this block.

Parameters:
ADDR_W, 24, byte address width of request and SDRAM read address
DATA_W, 16, line buffer / SDRAM data width
TIMEOUT, 255, max sd_clk cycles allowed between accepted address and each data beat before abort (8-bit compare)

Ports:
sd_clk  in  1  clock
rst  in  1  asynchronous active-high reset
qspi_rd_req  in  1  single-cycle prefetch request (already synchronised to sd_clk)
qspi_rd_addr  in  ADDR_W  line address; bits [3:0] ignored and forced to 0
qspi_rd_busy  out  1  high while a fill is in progress
rd_avalid  out  1  burst read address valid
rd_aready  in  1  SDRAM controller accepts address
rd_addr  out  ADDR_W  burst start address, 16-byte aligned
rd_valid  in  1  read data beat valid (no back-pressure)
rd_data  in  DATA_W  read data beat
ram_ren  in  1  buffer read strobe from QSPI responder
ram_raddr  in  3  buffer word index
ram_rdata  out  DATA_W  buf[ram_raddr], combinational
fill_done  out  1  one-cycle pulse when a fill ends (normal or aborted)
fill_err  out  1  sticky; set on timeout, cleared by the next accepted request
rd_hazard  out  1  one-cycle pulse when ram_ren is sampled while qspi_rd_busy=1

Behaviour:
- Reset (asynchronous, active-high, released synchronously): state=IDLE. qspi_rd_busy, rd_avalid, fill_done, fill_err, rd_hazard =0. rd_addr=0. All 8 buffer words=0. pending=0. beat_cnt=0. to_cnt=0.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE: when qspi_rd_req=1, latch {qspi_rd_addr[23:4],4'h0} into rd_addr, clear fill_err, go to ADDR. qspi_rd_busy rises the following cycle.
- ADDR: rd_avalid=1 and rd_addr is held stable. When rd_avalid&rd_aready: go to DATA, beat_cnt=0, to_cnt=0. rd_avalid drops the cycle after the handshake.
- DATA: each rd_valid writes buf[beat_cnt]<=rd_data, beat_cnt+1, to_cnt=0.
  - On rd_valid with beat_cnt==7: go to DONE.
  - Without rd_valid, to_cnt increments. When to_cnt==TIMEOUT: set fill_err=1, go to DONE. Words already written stay; remaining words keep their old contents.
  - rd_valid seen in ADDR or IDLE is ignored (no write).
- DONE: fill_done=1 for exactly one cycle.
  - If pending=1: load rd_addr from the pending address, clear pending and fill_err, go to ADDR. qspi_rd_busy stays high.
  - Otherwise go to IDLE. qspi_rd_busy=0 in the next cycle.
- qspi_rd_busy = (state != IDLE), registered.
- Request while busy (ADDR/DATA/DONE): set pending=1 and store the aligned address. A later request overwrites it (one-deep, last wins). A request in the same cycle as the DONE decision is captured as pending and serviced immediately after.
- Read port: ram_rdata = buf[ram_raddr], purely combinational, independent of ram_ren.
  - A write and a read of the same index in one cycle return the old value until the clock edge.
- rd_hazard: registered pulse, 1 cycle after ram_ren=1 with qspi_rd_busy=1. Informational only; does not stall the fill.
- Reset mid-fill: aborts immediately with no fill_done. Outstanding SDRAM beats arriving after reset release in IDLE are dropped.

Test Plan:
- Normal fill: qspi_rd_req with addr 0x12345A; aready after 3 cycles; 8 beats 0x1000..0x1007 back-to-back.
  - Expect rd_addr=0x123450 and a single rd_avalid handshake.
  - Expect buf[0..7]=0x1000..0x1007, one fill_done pulse, busy low afterwards.
- Gapped beats: beats separated by 0–10 idle cycles.
  - Expect the same buffer contents, fill_err=0, fill_done only after the 8th beat.
- Timeout: TIMEOUT=20; deliver 3 beats, then none.
  - Expect fill_err=1 and fill_done exactly 20 cycles after the 3rd beat.
  - Expect buf[0..2] new, buf[3..7] unchanged.
- Pending requests: during a fill, requests to 0x000100 then 0x000200.
  - Expect the second fill at rd_addr=0x000200 only, busy continuously high, two fill_done pulses.
- Read port and hazard: ram_raddr sweep 0..7 in IDLE returns buffer contents with zero latency.
  - ram_ren=1 during DATA gives one rd_hazard pulse; ram_ren in IDLE gives none.
- Reset mid-DATA after 4 beats: all outputs and buffer return to 0 asynchronously.
  - Later stray rd_valid writes nothing.
